// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Iterative RISC-V M-extension multiply/divide unit. One operand bit is
// processed per clock: shift-add for the multiplies, restoring
// shift-subtract for the divides. Signed operations iterate on magnitudes
// and fix up the sign in a final cycle, so latency is identical for every
// op, including divide-by-zero and signed overflow.
//
// Ports
//   clk     in   1     rising-edge clock
//   rst     in   1     asynchronous active-high reset
//   start   in   1     request pulse, sampled only while busy=0
//   op      in   3     funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   a       in   XLEN  multiplicand / dividend
//   b       in   XLEN  multiplier / divisor
//   busy    out  1     operation in progress
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  last completed result, held until the next one
// ---------------------------------------------------------------------------
module mul_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state;
   logic [CW-1:0]     count;
   logic              is_mul_r;
   logic              want_hi_r;
   logic              is_rem_r;
   logic              neg_r;
   logic [XLEN-1:0]   opnd_r;
   logic [2*XLEN-1:0] work_r;

   logic              a_signed;
   logic              b_signed;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic              start_neg;
   logic              accept;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] div_next;

   logic [2*XLEN-1:0] prod_fixed;
   logic [XLEN-1:0]   quo_mag;
   logic [XLEN-1:0]   rem_mag;
   logic [XLEN-1:0]   final_val;

   // Operand decode at request time: which operands are signed for this op,
   // their magnitudes, and the sign the final result must take. The
   // quotient of a divide by zero stays all ones regardless of the
   // dividend sign, so its negate is suppressed when b is zero. The
   // remainder always follows the dividend sign; with b zero this gives
   // back a unchanged.
   always_comb begin
      a_signed  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      b_signed  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      a_neg     = a_signed & a[XLEN-1];
      b_neg     = b_signed & b[XLEN-1];
      a_mag     = a_neg ? (~a + 1'b1) : a;
      b_mag     = b_neg ? (~b + 1'b1) : b;
      start_neg = 1'b0;
      if (!op[2]) begin
         start_neg = a_neg ^ b_neg;
      end else if (op[1]) begin
         start_neg = a_neg;
      end else begin
         start_neg = (a_neg ^ b_neg) & (b != '0);
      end
      accept = start && (state != CALC);
   end

   // One iteration step for each algorithm. work_r holds {acc, multiplier}
   // for multiplies and {remainder, dividend/quotient} for divides; both
   // shift one bit per cycle through the same register. The remainder is
   // always below the divisor, so when the trial subtract succeeds the
   // difference fits in XLEN bits and only the low bits are needed.
   always_comb begin
      mul_sum   = {1'b0, work_r[2*XLEN-1:XLEN]} + (work_r[0] ? {1'b0, opnd_r} : '0);
      mul_next  = {mul_sum, work_r[XLEN-1:1]};
      div_shift = {work_r[2*XLEN-1:XLEN], work_r[XLEN-1]};
      div_ge    = div_shift >= {1'b0, opnd_r};
      div_diff  = div_shift[XLEN-1:0] - opnd_r;
      if (div_ge) begin
         div_next = {div_diff, work_r[XLEN-2:0], 1'b1};
      end else begin
         div_next = {div_shift[XLEN-1:0], work_r[XLEN-2:0], 1'b0};
      end
   end

   // Sign fix-up and half selection once all iterations are done. The
   // full double-width product is negated so the upper half of signed
   // products carries the correct borrow from the lower half.
   always_comb begin
      prod_fixed = neg_r ? (~work_r + 1'b1) : work_r;
      quo_mag    = work_r[XLEN-1:0];
      rem_mag    = work_r[2*XLEN-1:XLEN];
      if (is_mul_r) begin
         final_val = want_hi_r ? prod_fixed[2*XLEN-1:XLEN] : prod_fixed[XLEN-1:0];
      end else if (is_rem_r) begin
         final_val = neg_r ? (~rem_mag + 1'b1) : rem_mag;
      end else begin
         final_val = neg_r ? (~quo_mag + 1'b1) : quo_mag;
      end
   end

   // Control and datapath registers. CALC spends XLEN cycles iterating
   // (count 0..XLEN-1) and one more with count==XLEN to apply the sign and
   // load result, so done appears XLEN+1 edges after the accepting edge.
   // A request is taken from IDLE or DONE, which lets a start held high
   // through DONE chain straight into the next operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         is_mul_r  <= 1'b0;
         want_hi_r <= 1'b0;
         is_rem_r  <= 1'b0;
         neg_r     <= 1'b0;
         opnd_r    <= '0;
         work_r    <= '0;
         result    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state     <= CALC;
                  count     <= '0;
                  is_mul_r  <= ~op[2];
                  want_hi_r <= (op[1:0] != 2'b00);
                  is_rem_r  <= op[1];
                  neg_r     <= start_neg;
                  if (!op[2]) begin
                     opnd_r <= a_mag;
                     work_r <= {{XLEN{1'b0}}, b_mag};
                  end else begin
                     opnd_r <= b_mag;
                     work_r <= {{XLEN{1'b0}}, a_mag};
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               if (count == CW'(XLEN)) begin
                  result <= final_val;
                  state  <= DONE;
               end else begin
                  work_r <= is_mul_r ? mul_next : div_next;
                  count  <= count + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status outputs decode directly from the state register.
   always_comb begin
      busy = (state == CALC);
      done = (state == DONE);
   end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

   localparam logic [2:0] MUL    = 3'd0;
   localparam logic [2:0] MULH   = 3'd1;
   localparam logic [2:0] MULHSU = 3'd2;
   localparam logic [2:0] MULHU  = 3'd3;
   localparam logic [2:0] DIV    = 3'd4;
   localparam logic [2:0] DIVU   = 3'd5;
   localparam logic [2:0] REM    = 3'd6;
   localparam logic [2:0] REMU   = 3'd7;

   logic        clk;
   logic        rst;
   logic        start32;
   logic [2:0]  op32;
   logic [31:0] a32;
   logic [31:0] b32;
   logic        busy32;
   logic        done32;
   logic [31:0] result32;

   logic        start8;
   logic [2:0]  op8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        busy8;
   logic        done8;
   logic [7:0]  result8;

   int checks;
   int errors;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   mul_div_unit #(.XLEN(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .result(result32)
   );

   mul_div_unit #(.XLEN(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(result8)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Backstop in case something stalls outside the bounded loops.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference behaviour from the M-extension arithmetic rules, using wide
   // integer math on w-bit operands.
   function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input int w);
      longint      mask;
      longint      ua;
      longint      ub;
      longint      sa;
      longint      sb;
      longint      r;
      logic [63:0] up;
      mask = (longint'(1) << w) - 1;
      ua   = longint'(x) & mask;
      ub   = longint'(y) & mask;
      sa   = ua;
      sb   = ub;
      if (ua[w-1]) sa = ua - (longint'(1) << w);
      if (ub[w-1]) sb = ub - (longint'(1) << w);
      case (o)
         MUL:    r = sa * sb;
         MULH:   r = (sa * sb) >>> w;
         MULHSU: r = (sa * ub) >>> w;
         MULHU:  begin up = 64'(ua) * 64'(ub); r = longint'(up >> w); end
         DIV:    r = (ub == 0) ? mask : sa / sb;
         DIVU:   r = (ub == 0) ? mask : ua / ub;
         REM:    r = (ub == 0) ? sa : sa % sb;
         default: r = (ub == 0) ? ua : ua % ub;
      endcase
      return 32'(r & mask);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request to either DUT and follow it to its done pulse.
   // Operands are scrambled right after the accepting edge to show they
   // were latched. lat counts edges after the accepting edge.
   task automatic applyStimulus(input bit narrow, input logic [2:0] o, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] res,
                                output int lat, output logic busyOk);
      logic dn;
      logic bz;
      if (narrow) begin
         op8 = o; a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1;
      end else begin
         op32 = o; a32 = x; b32 = y; start32 = 1'b1;
      end
      @(posedge clk);
      #1;
      start8 = 1'b0;
      start32 = 1'b0;
      op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
      busyOk = narrow ? busy8 : busy32;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         dn = narrow ? done8 : done32;
         bz = narrow ? busy8 : busy32;
         if (dn) begin
            busyOk = busyOk & ~bz;
            break;
         end
         busyOk = busyOk & bz;
      end
      res = narrow ? 32'(result8) : result32;
   endtask

   initial begin
      logic [31:0] res;
      logic [31:0] res1;
      logic [31:0] res2;
      logic [31:0] exp1;
      logic [31:0] exp2;
      logic [31:0] x;
      logic [31:0] y;
      logic [2:0]  o;
      logic        bok;
      int          lat;
      int          first;
      int          second;
      int          doneCount;
      bit          doneSeen;

      checks = 0;
      errors = 0;
      rst = 1'b1;
      start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;

      // Reset state, before any clock edge.
      #1;
      checkOutput("reset busy", 64'(busy32), 64'd0);
      checkOutput("reset done", 64'(done32), 64'd0);
      checkOutput("reset result", 64'(result32), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      vecs.push_back('{"MUL 7x-3",      MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB});
      vecs.push_back('{"MULH min*min",  MULH,   32'h80000000,   32'h80000000, 32'h40000000});
      vecs.push_back('{"MULHU max*max", MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE});
      vecs.push_back('{"MULHSU -1*max", MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF});
      vecs.push_back('{"DIV -7/2",      DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD});
      vecs.push_back('{"REM -7/2",      REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF});
      vecs.push_back('{"DIVU -7/2",     DIVU,   32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC});
      vecs.push_back('{"REMU -7/2",     REMU,   32'hFFFFFFF9,   32'd2,        32'd1});
      vecs.push_back('{"DIVU 5/0",      DIVU,   32'd5,          32'd0,        32'hFFFFFFFF});
      vecs.push_back('{"REMU 5/0",      REMU,   32'd5,          32'd0,        32'd5});
      vecs.push_back('{"DIV ovf",       DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000});
      vecs.push_back('{"REM ovf",       REM,    32'h80000000,   32'hFFFFFFFF, 32'd0});
      vecs.push_back('{"DIV -7/0",      DIV,    32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF});
      vecs.push_back('{"REM -7/0",      REM,    32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9});

      foreach (vecs[i]) begin
         applyStimulus(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bok);
         checkOutput({vecs[i].name, " result"}, 64'(res), 64'(vecs[i].exp));
         checkOutput({vecs[i].name, " latency"}, 64'(lat), 64'd33);
         checkOutput({vecs[i].name, " busy"}, 64'(bok), 64'd1);
         @(posedge clk);
         #1;
         checkOutput({vecs[i].name, " done drop"}, 64'(done32), 64'd0);
         checkOutput({vecs[i].name, " held"}, 64'(result32), 64'(vecs[i].exp));
      end

      // Second start during CALC must be ignored.
      exp1 = refModel(MUL, 32'd1234, 32'd5678, 32);
      op32 = MUL; a32 = 32'd1234; b32 = 32'd5678; start32 = 1'b1;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      first = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 5) begin
            op32 = DIVU; a32 = 32'd999; b32 = 32'd3; start32 = 1'b1;
         end
         @(posedge clk);
         #1;
         if (k == 5) start32 = 1'b0;
         if (done32 && first == 0) begin
            first = k;
            res1 = result32;
         end
      end
      checkOutput("ignored start latency", 64'(first), 64'd33);
      checkOutput("ignored start result", 64'(res1), 64'(exp1));

      // Start held high through DONE chains a second operation.
      exp1 = refModel(MULHU, 32'hDEADBEEF, 32'h12345678, 32);
      exp2 = refModel(DIV, 32'hF0000001, 32'd7, 32);
      op32 = MULHU; a32 = 32'hDEADBEEF; b32 = 32'h12345678; start32 = 1'b1;
      @(posedge clk);
      #1;
      op32 = DIV; a32 = 32'hF0000001; b32 = 32'd7;
      first = 0; second = 0; doneCount = 0; res1 = '0; res2 = '0;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk);
         #1;
         if (done32) begin
            doneCount++;
            if (first == 0) begin
               first = k; res1 = result32;
            end else begin
               second = k; res2 = result32; start32 = 1'b0;
               break;
            end
         end
      end
      start32 = 1'b0;
      checkOutput("b2b first latency", 64'(first), 64'd33);
      checkOutput("b2b first result", 64'(res1), 64'(exp1));
      checkOutput("b2b second latency", 64'(second), 64'd67);
      checkOutput("b2b second result", 64'(res2), 64'(exp2));
      checkOutput("b2b done count", 64'(doneCount), 64'd2);
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of an operation.
      op32 = MUL; a32 = 32'd55; b32 = 32'd66; start32 = 1'b1;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("mid reset busy", 64'(busy32), 64'd0);
      checkOutput("mid reset done", 64'(done32), 64'd0);
      checkOutput("mid reset result", 64'(result32), 64'd0);
      #2;
      rst = 1'b0;
      applyStimulus(1'b0, MUL, 32'd3, 32'd4, res, lat, bok);
      checkOutput("post reset MUL result", 64'(res), 64'd12);
      checkOutput("post reset MUL latency", 64'(lat), 64'd33);
      doneSeen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (done32) doneSeen = 1'b1;
      end
      checkOutput("no stray done", 64'(doneSeen), 64'd0);

      // Random 32-bit operations against the model.
      for (int k = 0; k < 30; k++) begin
         o = 3'($urandom);
         x = $urandom;
         y = (k % 6 == 0) ? 32'd0 : ((k % 4 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
         applyStimulus(1'b0, o, x, y, res, lat, bok);
         checkOutput($sformatf("rand32 op%0d a=%h b=%h", o, x, y), 64'(res), 64'(refModel(o, x, y, 32)));
         checkOutput("rand32 latency", 64'(lat), 64'd33);
      end

      // XLEN=8 sweep across all ops, including zero divisor and overflow.
      for (int k = 0; k < 160; k++) begin
         o = 3'(k % 8);
         x = 32'($urandom_range(0, 255));
         y = 32'($urandom_range(0, 255));
         if (k % 11 == 0) y = 32'd0;
         if (k % 13 == 0) begin
            x = 32'h80; y = 32'hFF;
         end
         applyStimulus(1'b1, o, x, y, res, lat, bok);
         checkOutput($sformatf("rand8 op%0d a=%h b=%h", o, x, y), 64'(res), 64'(refModel(o, x, y, 8)));
         checkOutput("rand8 latency", 64'(lat), 64'd9);
         checkOutput("rand8 busy", 64'(bok), 64'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
